vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 38 +++
 rtl/vga_timing_gen_pixel_strobe_div.sv | 40 ++++
 rtl/vga_timing_gen.sv | 129 ++++++++++++
 tb/tb_vga_timing_gen.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing shared by vga_timing_gen and the renderer blocks,
// plus the raster counter types and a small window-decode helper.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    cnt_t v;
    cnt_t h;
  } raster_t;

  localparam int VGA_CLK_DIV   = 4;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // Inclusive sync windows, in counter units (0 = first visible pixel/line).
  localparam int VGA_HS_START  = VGA_H_VISIBLE + VGA_H_FRONT;
  localparam int VGA_HS_END    = VGA_HS_START + VGA_H_SYNC - 1;
  localparam int VGA_VS_START  = VGA_V_VISIBLE + VGA_V_FRONT;
  localparam int VGA_VS_END    = VGA_VS_START + VGA_V_SYNC - 1;

  function automatic logic in_window(input cnt_t c, input cnt_t lo, input cnt_t hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_strobe_div.sv
// pixel_strobe_div: divides clk into a one-cycle pixel strobe every CLK_DIV clocks.
// The strobe is registered so it reads 0 while in reset even when CLK_DIV is 1.
module pixel_strobe_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic pixel_en_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef logic [DIV_W-1:0] div_t;

  localparam div_t DIV_LAST = div_t'(CLK_DIV - 1);

  div_t div_q;
  div_t div_d;
  logic pixel_en_q;
  logic pixel_en_d;

  always_comb begin
    div_d      = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    // Strobe lines up with the cycle in which div_q sits at its last value.
    pixel_en_d = (div_d == DIV_LAST);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_q      <= '0;
      pixel_en_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      pixel_en_q <= pixel_en_d;
    end
  end

  assign pixel_en_o = pixel_en_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, active-low syncs, bright and line/frame start pulses.
// Define VGA_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = VGA_CLK_DIV,
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             pixel_en,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic             hSync,
  output logic             vSync,
  output logic             bright,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 1024) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL exceeds the 10-bit counter range");
  end
  if (V_TOTAL > 1024) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL exceeds the 10-bit counter range");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be in 1..16");
  end

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_VIS  = cnt_t'(H_VISIBLE);
  localparam cnt_t V_VIS  = cnt_t'(V_VISIBLE);
  localparam cnt_t HS_LO  = cnt_t'(H_VISIBLE + H_FRONT);
  localparam cnt_t HS_HI  = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam cnt_t VS_LO  = cnt_t'(V_VISIBLE + V_FRONT);
  localparam cnt_t VS_HI  = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic    pixel_en_w;
  raster_t raster_q;
  raster_t raster_d;
  logic    hsync_q;
  logic    hsync_d;
  logic    vsync_q;
  logic    vsync_d;
  logic    bright_q;
  logic    bright_d;

  pixel_strobe_div #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .pixel_en_o(pixel_en_w)
  );

  always_comb begin
    raster_d = raster_q;
    if (pixel_en_w) begin
      if (raster_q.h == H_LAST) begin
        raster_d.h = '0;
        raster_d.v = (raster_q.v == V_LAST) ? '0 : raster_q.v + 1'b1;
      end else begin
        raster_d.h = raster_q.h + 1'b1;
      end
    end
  end

  // Decoding the next-state counters lets the registered flags line up with the
  // counters they describe, with no extra cycle of lag.
  always_comb begin
    hsync_d  = !in_window(raster_d.h, HS_LO, HS_HI);
    vsync_d  = !in_window(raster_d.v, VS_LO, VS_HI);
    bright_d = (raster_d.h < H_VIS) && (raster_d.v < V_VIS);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      raster_q <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      bright_q <= 1'b0;
    end else begin
      raster_q <= raster_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      bright_q <= bright_d;
    end
  end

  assign pixel_en    = pixel_en_w;
  assign hCount      = raster_q.h;
  assign vCount      = raster_q.v;
  assign hSync       = hsync_q;
  assign vSync       = vsync_q;
  assign bright      = bright_q;
  assign line_start  = pixel_en_w && (raster_q.h == '0);
  assign frame_start = line_start && (raster_q.v == '0);

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (frame_start) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default timing (A), a shrunken 14x8 raster with CLK_DIV=2 (B),
// and default timing with CLK_DIV=1 (C).
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  logic pe_a, hs_a, vs_a, br_a, ls_a, fs_a;
  logic pe_b, hs_b, vs_b, br_b, ls_b, fs_b;
  logic pe_c, hs_c, vs_c, br_c, ls_c, fs_c;
  logic [9:0] hc_a, vc_a, hc_b, vc_b, hc_c, vc_c;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] fc_a, fc_b, fc_c;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int t, hs_low, vs_low, br_cnt, fs_cnt, ls_cnt, zeros, bad, lo, hi, br_max;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  vga_timing_gen #(.CLK_DIV(4)) dut_a (
    .clk(clk), .rst_n(rst_a), .pixel_en(pe_a), .hCount(hc_a), .vCount(vc_a),
    .hSync(hs_a), .vSync(vs_a), .bright(br_a), .line_start(ls_a), .frame_start(fs_a)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc_a)
`endif
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_b), .pixel_en(pe_b), .hCount(hc_b), .vCount(vc_b),
    .hSync(hs_b), .vSync(vs_b), .bright(br_b), .line_start(ls_b), .frame_start(fs_b)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc_b)
`endif
  );

  vga_timing_gen #(.CLK_DIV(1)) dut_c (
    .clk(clk), .rst_n(rst_c), .pixel_en(pe_c), .hCount(hc_c), .vCount(vc_c),
    .hSync(hs_c), .vSync(vs_c), .bright(br_c), .line_start(ls_c), .frame_start(fs_c)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc_c)
`endif
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_pixel_en", pe_a, 0);
    check("rst_hcount", hc_a, 0);
    check("rst_vcount", vc_a, 0);
    check("rst_hsync", hs_a, 1);
    check("rst_vsync", vs_a, 1);
    check("rst_bright", br_a, 0);
    check("rst_line_start", ls_a, 0);
    check("rst_frame_start", fs_a, 0);
    check("rst_pixel_en_div1", pe_c, 0);
`ifdef VGA_FRAME_CNT_EN
    check("rst_frame_cnt", fc_a, 0);
`endif

    // Release: strobes at cycles 3, 7, 11; hCount steps after the first strobe
    rst_a = 1'b1;
    for (int k = 0; k < 12; k++) begin
      check($sformatf("a_pe_cyc%0d", k), pe_a, (k % 4 == 3) ? 1 : 0);
      if (k == 0) check("a_bright_cyc0", br_a, 0);
      if (k == 1) check("a_bright_cyc1", br_a, 1);
      if (k == 3) check("a_first_frame_start", fs_a, 1);
      if (k == 3) check("a_hcount_cyc3", hc_a, 0);
      if (k == 4) check("a_hcount_cyc4", hc_a, 1);
      @(negedge clk);
    end

    // One full line on A, starting at the line_start of line 1 (cycle 3203)
    t = 0;
    while (!ls_a && t < 4000) begin @(negedge clk); t++; end
    check("a_line1_delay", t, 3191);
    hs_low = 0; br_cnt = 0; bad = 0; lo = 1023; hi = 0; br_max = 0;
    for (int k = 0; k < 3200; k++) begin
      if (pe_a && !hs_a) begin
        hs_low++;
        if (hc_a < lo) lo = hc_a;
        if (hc_a > hi) hi = hc_a;
      end
      if (pe_a && br_a) begin
        br_cnt++;
        if (hc_a > br_max) br_max = hc_a;
      end
      if (hs_a !== !(hc_a >= 656 && hc_a <= 751)) bad++;
      if (br_a !== (hc_a < 640 && vc_a < 480)) bad++;
      if (vs_a !== 1'b1) bad++;
      @(negedge clk);
    end
    check("a_hsync_low_pixels", hs_low, 96);
    check("a_hsync_first", lo, 656);
    check("a_hsync_last", hi, 751);
    check("a_bright_pixels", br_cnt, 640);
    check("a_bright_last", br_max, 639);
    check("a_line_flag_errors", bad, 0);
    check("a_line_period", ls_a, 1);
    check("a_vcount_line2", vc_a, 2);

    // Mid-line reset at hCount 700
    t = 0;
    while (hc_a != 10'd700 && t < 4000) begin @(negedge clk); t++; end
    check("a_reach_700", hc_a, 700);
    check("a_hsync_at_700", hs_a, 0);
    rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    check("a_mid_rst_hcount", hc_a, 0);
    check("a_mid_rst_vcount", vc_a, 0);
    check("a_mid_rst_hsync", hs_a, 1);
    check("a_mid_rst_bright", br_a, 0);
    check("a_mid_rst_pe", pe_a, 0);
    repeat (3) @(negedge clk);
    check("a_resume_pe", pe_a, 1);
    check("a_resume_frame_start", fs_a, 1);
    @(negedge clk);
    check("a_resume_hcount", hc_a, 1);

    // Shrunken raster: 14 pixels x 8 lines, 2 clk per pixel -> 224 clk per frame
    rst_b = 1'b1;
    @(negedge clk);
    check("b_first_frame_start", fs_b, 1);
    fs_cnt = 0; vs_low = 0; hs_low = 0; br_cnt = 0; lo = 1023; hi = 0;
    for (int k = 0; k < 224; k++) begin
      if (fs_b) fs_cnt++;
      if (!hs_b) hs_low++;
      if (br_b) br_cnt++;
      if (!vs_b) begin
        vs_low++;
        if (vc_b < lo) lo = vc_b;
        if (vc_b > hi) hi = vc_b;
      end
      @(negedge clk);
    end
    check("b_frame_starts", fs_cnt, 1);
    check("b_vsync_low_clks", vs_low, 56);
    check("b_vsync_first", lo, 5);
    check("b_vsync_last", hi, 6);
    check("b_hsync_low_clks", hs_low, 48);
    check("b_bright_clks", br_cnt, 64);
    check("b_frame_period", fs_b, 1);
`ifdef VGA_FRAME_CNT_EN
    check("b_frame_cnt_one", fc_b, 1);
    @(negedge clk);
    force dut_b.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut_b.frame_cnt_q;
    t = 0;
    while (!fs_b && t < 300) begin @(negedge clk); t++; end
    check("b_fs_before_wrap", fs_b, 1);
    check("b_frame_cnt_max", fc_b, 65535);
    @(negedge clk);
    check("b_frame_cnt_wrap", fc_b, 0);
`endif

    // Mid-frame reset inside both sync windows
    t = 0;
    while (!(hc_b == 10'd10 && vc_b == 10'd5) && t < 300) begin @(negedge clk); t++; end
    check("b_reach_10_5", {hc_b, vc_b}, {10'd10, 10'd5});
    check("b_vsync_at_5", vs_b, 0);
    check("b_hsync_at_10", hs_b, 0);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    check("b_mid_rst_vsync", vs_b, 1);
    check("b_mid_rst_hsync", hs_b, 1);
    check("b_mid_rst_counts", {hc_b, vc_b}, 0);
    @(negedge clk);
    check("b_resume_frame_start", fs_b, 1);
    check("b_resume_bright", br_b, 1);

    // CLK_DIV = 1: strobe always high after reset, 800 clk per line
    rst_c = 1'b1;
    @(negedge clk);
    zeros = 0; ls_cnt = 0;
    for (int k = 0; k < 800; k++) begin
      if (!pe_c) zeros++;
      if (ls_c) ls_cnt++;
      if (k == 0) check("c_hcount_cyc1", hc_c, 0);
      if (k == 1) check("c_hcount_cyc2", hc_c, 1);
      @(negedge clk);
    end
    check("c_pe_low_cycles", zeros, 0);
    check("c_line_starts", ls_cnt, 1);
    check("c_line_period", ls_c, 1);
    check("c_vcount_line1", vc_c, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
